// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq -- sequential carry-propagate resolver for the 4:2
// compressor output. Accepts one redundant (sum, carry) pair and resolves
// result = sum + (carry << 1) CHUNK bits per cycle through a narrow adder slice.
//
// Optional feature macro: CSA_RESOLVE_EARLY_TERM_EN
//   defined   : ADD stops early once the remaining upper chunks of both
//               operands are zero and the current chunk produced no carry.
//   undefined : fixed NCH-cycle resolve latency, no zero-detect logic.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_in_valid   sum/carry pair valid
//   o_in_ready   block can accept a pair (IDLE, not in reset)
//   i_sum_in     compressor sum vector
//   i_carry_in   compressor carry vector, bit i weighs 2^(i+1)
//   o_out_valid  result valid (DONE)
//   i_out_ready  downstream accepts result
//   o_result     resolved binary value, W+2 bits
//   o_busy       high while resolving (ADD)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an input pair
// S_ADD  | resolving one chunk per edge, chunk index r_idx
// S_DONE | result presented, holding until downstream accepts it

module csa_resolve_seq #(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_sum_in,
  input  logic [W-1:0] i_carry_in,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W+1:0] o_result,
  output logic         o_busy
);

  localparam int RW  = W + 2;
  localparam int NCH = (RW + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NCH - 1);
  localparam logic [PW-1:0] CHUNK_MASK = PW'({CHUNK{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_b;
  logic [PW-1:0]   r_acc;
  logic            r_cy;
  logic [IW-1:0]   r_idx;

  logic [31:0]     w_ofs;
  logic [PW-1:0]   w_a_sh;
  logic [PW-1:0]   w_b_sh;
  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK:0]  w_ch_sum;
  logic            w_last;
  logic            w_accept;
  logic            w_early;

  // Chunk selection by shifting keeps the slice logic a plain mux tree.
  assign w_ofs    = 32'(r_idx) * CHUNK;
  assign w_a_sh   = r_a >> w_ofs;
  assign w_b_sh   = r_b >> w_ofs;
  assign w_a_ch   = w_a_sh[CHUNK-1:0];
  assign w_b_ch   = w_b_sh[CHUNK-1:0];
  assign w_ch_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_cy};
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = (r_state == S_IDLE) && i_in_valid;

`ifdef CSA_RESOLVE_EARLY_TERM_EN
  logic [PW-1:0] w_upper;
  // Everything above the current chunk; shifts past PW simply yield zero.
  assign w_upper = (r_a | r_b) >> (w_ofs + 32'(CHUNK));
  assign w_early = (w_upper == '0) && !w_ch_sum[CHUNK] && !w_last;
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Held low while reset is applied even though the state is IDLE.
        o_in_ready = ~i_rst;
        if (i_in_valid) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        o_busy = 1'b1;
        if (w_last || w_early) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cy  <= 1'b0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_a   <= PW'(i_sum_in);
      r_b   <= PW'({i_carry_in, 1'b0});
      r_acc <= '0;
      r_cy  <= 1'b0;
      r_idx <= '0;
    end else if (r_state == S_ADD) begin
      r_acc <= (r_acc & ~(CHUNK_MASK << w_ofs)) |
               (PW'(w_ch_sum[CHUNK-1:0]) << w_ofs);
      // Carry out of the last chunk is always zero thanks to the padding.
      r_cy  <= w_ch_sum[CHUNK];
      r_idx <= r_idx + IW'(1);
    end
  end

  assign o_result = r_acc[RW-1:0];

endmodule

// File: tb/tb_csa_resolve_seq.sv
module tb_csa_resolve_seq;

  localparam int W     = 16;
  localparam int CHUNK = 4;
  localparam int RW    = W + 2;
  localparam int NCH   = (RW + CHUNK - 1) / CHUNK;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_sum_in;
  logic [W-1:0]  i_carry_in;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [RW-1:0] o_result;
  logic          o_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  csa_resolve_seq #(.W(W), .CHUNK(CHUNK)) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_sum_in    (i_sum_in),
    .i_carry_in  (i_carry_in),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_busy      (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] model_res(input logic [W-1:0] s, input logic [W-1:0] c);
    return RW'(s) + (RW'(c) << 1);
  endfunction

  function automatic int model_lat(input logic [W-1:0] s, input logic [W-1:0] c);
`ifdef CSA_RESOLVE_EARLY_TERM_EN
    int a, b, m, sh;
    a = int'(s);
    b = int'(c) << 1;
    for (int k = 0; k < NCH - 1; k++) begin
      sh = CHUNK * (k + 1);
      m  = (1 << sh) - 1;
      if ((((a | b) >> sh) == 0) && ((((a & m) + (b & m)) >> sh) == 0)) return k + 1;
    end
`endif
    return NCH;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_txn(input logic [W-1:0] s, input logic [W-1:0] c,
                         input int bp, input string tag);
    int lat;
    chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_sum_in    = s;
    i_carry_in  = c;
    tick();
    i_in_valid = 1'b0;
    i_sum_in   = W'($urandom);
    i_carry_in = W'($urandom);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!o_out_valid && lat < 40);
    chk({tag, "_lat"}, 32'(lat), 32'(model_lat(s, c)));
    chk({tag, "_res"}, 32'(o_result), 32'(model_res(s, c)));
    chk({tag, "_busy_done"}, 32'(o_busy), 32'd0);
    for (int k = 0; k < bp; k++) begin
      tick();
      chk({tag, "_hold"}, 32'({o_out_valid, o_in_ready, o_result}),
          32'({1'b1, 1'b0, model_res(s, c)}));
    end
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    chk({tag, "_handoff"}, 32'({o_out_valid, o_in_ready}), 32'b01);
  endtask

  initial begin
    int lat, t, sent;
    logic acc_now;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int acc_t[$];
    int out_t[$];
    int lat_q[$];

    i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_sum_in = '0; i_carry_in = '0;
    #12;
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_outs", 32'({o_out_valid, o_busy, o_result}), 32'd0);
    #4 i_rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(o_in_ready), 32'd1);

    run_txn(16'h0003, 16'h0001, 0, "basic");
    run_txn(16'hFFFF, 16'hFFFF, 0, "ripple");
    run_txn(16'h00A5, 16'h0042, 10, "bp");

    // Input changes during ADD must be ignored.
    i_in_valid = 1'b1; i_sum_in = 16'h1234; i_carry_in = 16'h0010;
    tick();
    i_sum_in = 16'hFFFF; i_carry_in = 16'hFFFF;
    lat = 0;
    do begin
      chk("ign_busy", 32'({o_busy, o_in_ready}), 32'b10);
      tick();
      lat++;
    end while (!o_out_valid && lat < 40);
    chk("ign_lat", 32'(lat), 32'(model_lat(16'h1234, 16'h0010)));
    chk("ign_res", 32'(o_result), 32'h01254);
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    tick(); tick();
    chk("ign_no_second", 32'({o_out_valid, o_busy, o_in_ready}), 32'b001);

    // Asynchronous reset during the third ADD cycle.
    i_in_valid = 1'b1; i_sum_in = 16'hABCD; i_carry_in = 16'h1111;
    tick();
    i_in_valid = 1'b0;
    tick(); tick();
    chk("mid_busy", 32'(o_busy), 32'd1);
    #3 i_rst = 1'b1;
    #1;
    chk("mid_rst_outs", 32'({o_out_valid, o_busy, o_result}), 32'd0);
    chk("mid_rst_in_ready", 32'(o_in_ready), 32'd0);
    tick();
    chk("mid_rst_hold", 32'({o_out_valid, o_busy, o_result}), 32'd0);
    #2 i_rst = 1'b0;
    tick();
    chk("mid_rel", 32'({o_in_ready, o_out_valid}), 32'b10);
    run_txn(16'h0001, 16'h0000, 0, "after_rst");

    // Back-to-back with in_valid and out_ready held high.
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1; i_sum_in = 16'h8000; i_carry_in = 16'h8000;
    t = 0; sent = 0;
    while (got_q.size() < 2 && t < 60) begin
      acc_now = o_in_ready && i_in_valid;
      if (acc_now) begin
        exp_q.push_back(model_res(i_sum_in, i_carry_in));
        lat_q.push_back(model_lat(i_sum_in, i_carry_in));
        acc_t.push_back(t);
      end
      if (o_out_valid) begin
        got_q.push_back(o_result);
        out_t.push_back(t);
      end
      tick();
      t++;
      if (acc_now) begin
        sent++;
        if (sent == 1) begin
          i_sum_in = 16'h0000; i_carry_in = 16'h0000;
        end else begin
          i_in_valid = 1'b0;
        end
      end
    end
    i_out_ready = 1'b0;
    i_in_valid  = 1'b0;
    chk("b2b_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2 && acc_t.size() >= 2 && out_t.size() >= 2) begin
      chk("b2b_res0", 32'(got_q[0]), 32'h18000);
      chk("b2b_res1", 32'(got_q[1]), 32'h00000);
      chk("b2b_model0", 32'(got_q[0]), 32'(exp_q[0]));
      chk("b2b_acc_gap", 32'(acc_t[1] - acc_t[0]), 32'(NCH + 2));
      chk("b2b_out_gap", 32'(out_t[1] - out_t[0]),
          32'(acc_t[1] - acc_t[0] + lat_q[1] - lat_q[0]));
    end
    tick();

    // Randomized pairs with random backpressure; odd passes use small values.
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] s, c;
      s = W'($urandom);
      c = W'($urandom);
      if (n % 2 == 1) begin
        s = s & W'(16'h00FF >> $urandom_range(0, 7));
        c = c & W'(16'h0FFF >> $urandom_range(0, 11));
      end
      run_txn(s, c, $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
